// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: fetch tracking states and the
// decode/execute fields needed for load-use detection.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned LU_BUBBLES_MAX = 3;
  localparam int unsigned LU_CNT_W       = 2;

  typedef enum logic [1:0] {
    F_IDLE,
    F_BUSY,
    F_DROP
  } fetch_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;
  } id_fields_t;

  typedef struct packed {
    logic             valid;
    logic             is_load;
    logic [REG_W-1:0] rd;
  } ex_fields_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline is the master,
// the controller is the slave.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1_s;
  logic [REG_W-1:0] id_rs2_s;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd_s;
  logic             ex_redirect;
  logic             imem_rqst;
  logic             imem_resp;
  logic             dmem_rqst;
  logic             dmem_resp;

  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             imem_drop;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_valid, id_rs1_s, id_rs2_s, id_rs1_used, id_rs2_used,
    input  ex_valid, ex_is_load, ex_rd_s, ex_redirect,
    input  imem_rqst, imem_resp, dmem_rqst, dmem_resp,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output id_ex_bubble, if_id_flush, imem_drop, stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rs1_s, id_rs2_s, id_rs1_used, id_rs2_used,
    output ex_valid, ex_is_load, ex_rd_s, ex_redirect,
    output imem_rqst, imem_resp, dmem_rqst, dmem_resp,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  id_ex_bubble, if_id_flush, imem_drop, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Flags a decode instruction that reads the destination of a load still in
// EX, i.e. a dependency forwarding cannot cover. x0 never creates a hazard.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  id_fields_t id,
  input  ex_fields_t ex,
  output logic       lu_hit_c
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id.rs1_used && (id.rs1 == ex.rd);
  assign rs2_match = id.rs2_used && (id.rs2 == ex.rd);
  assign lu_hit_c  = id.valid && ex.valid && ex.is_load && (ex.rd != '0) &&
                     (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle advance/bubble/flush decisions for
// memory waits, load-use hazards and EX redirects, plus stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  fetch_state_t        fetch_q, fetch_d;
  logic                dmem_busy_q;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    flush_cnt_q;

  logic freeze_c;
  logic redirect_now_c;
  logic lu_hit_c;
  logic pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c;
  logic id_ex_bubble_c, if_id_flush_c, imem_drop_c;

  id_fields_t id_f;
  ex_fields_t ex_f;

  assign id_f = '{valid: bus.id_valid, rs1: bus.id_rs1_s, rs2: bus.id_rs2_s,
                  rs1_used: bus.id_rs1_used, rs2_used: bus.id_rs2_used};
  assign ex_f = '{valid: bus.ex_valid, is_load: bus.ex_is_load, rd: bus.ex_rd_s};

  load_use_detect u_lu (
    .id       (id_f),
    .ex       (ex_f),
    .lu_hit_c (lu_hit_c)
  );

  // Any outstanding memory access without its response holds the whole pipe.
  assign freeze_c = (dmem_busy_q && !bus.dmem_resp) ||
                    (fetch_q == F_BUSY && !bus.imem_resp) ||
                    (fetch_q == F_DROP);
  assign redirect_now_c = bus.ex_valid && bus.ex_redirect && !freeze_c;

  always_comb begin
    fetch_d        = fetch_q;
    lu_cnt_d       = lu_cnt_q;
    pc_we_c        = 1'b0;
    if_id_we_c     = 1'b0;
    id_ex_we_c     = 1'b0;
    ex_mem_we_c    = 1'b0;
    mem_wb_we_c    = 1'b0;
    id_ex_bubble_c = 1'b0;
    if_id_flush_c  = 1'b0;
    imem_drop_c    = 1'b0;

    unique case (fetch_q)
      F_IDLE: begin
        if (bus.imem_rqst) fetch_d = F_BUSY;
      end
      F_BUSY: begin
        if (bus.imem_resp) begin
          imem_drop_c = redirect_now_c;
          fetch_d     = bus.imem_rqst ? F_BUSY : F_IDLE;
        end else if (redirect_now_c) begin
          fetch_d = F_DROP;
        end
      end
      F_DROP: begin
        imem_drop_c = bus.imem_resp;
        if (bus.imem_resp) fetch_d = bus.imem_rqst ? F_BUSY : F_IDLE;
      end
      default: fetch_d = F_IDLE;
    endcase

    if (freeze_c) begin
      lu_cnt_d = lu_cnt_q;
    end else if (redirect_now_c) begin
      pc_we_c        = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_we_c     = 1'b1;
      id_ex_bubble_c = 1'b1;
      ex_mem_we_c    = 1'b1;
      mem_wb_we_c    = 1'b1;
      lu_cnt_d       = '0;
    end else if (lu_hit_c || lu_cnt_q != '0) begin
      id_ex_we_c     = 1'b1;
      id_ex_bubble_c = 1'b1;
      ex_mem_we_c    = 1'b1;
      mem_wb_we_c    = 1'b1;
      lu_cnt_d       = (lu_hit_c && lu_cnt_q == '0) ? LU_CNT_W'(LU_BUBBLES - 1)
                                                    : lu_cnt_q - LU_CNT_W'(1);
    end else begin
      pc_we_c     = 1'b1;
      if_id_we_c  = 1'b1;
      id_ex_we_c  = 1'b1;
      ex_mem_we_c = 1'b1;
      mem_wb_we_c = 1'b1;
    end

    // Reset overrides everything and keeps IF/ID invalid.
    if (rst) begin
      pc_we_c        = 1'b0;
      if_id_we_c     = 1'b0;
      id_ex_we_c     = 1'b0;
      ex_mem_we_c    = 1'b0;
      mem_wb_we_c    = 1'b0;
      id_ex_bubble_c = 1'b0;
      if_id_flush_c  = 1'b1;
      imem_drop_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q     <= F_IDLE;
      dmem_busy_q <= 1'b0;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_q     <= fetch_d;
      dmem_busy_q <= bus.dmem_rqst || (dmem_busy_q && !bus.dmem_resp);
      lu_cnt_q    <= lu_cnt_d;
      if (!pc_we_c && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_now_c && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_we        = pc_we_c;
  assign bus.if_id_we     = if_id_we_c;
  assign bus.id_ex_we     = id_ex_we_c;
  assign bus.ex_mem_we    = ex_mem_we_c;
  assign bus.mem_wb_we    = mem_wb_we_c;
  assign bus.id_ex_bubble = id_ex_bubble_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.imem_drop    = imem_drop_c;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
